// File: rtl/div_gen.sv
// -----------------------------------------------------------------------------
// div_gen -- iterative radix-2 restoring divider, signed or unsigned.
//
// A start request on en (accepted in IDLE or DONE) latches the operands and
// mode, then the divider spends WIDTH cycles in CALC producing one quotient
// bit per cycle, and one cycle in FIX applying signs and publishing the
// result. A zero divisor skips CALC and reports dbz.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset
//   en    in   start request
//   sgn   in   0 = unsigned, 1 = two's-complement signed (sampled with en)
//   y     in   dividend (sampled with en)
//   x     in   divisor  (sampled with en)
//   q     out  quotient, registered, held until the next result
//   r     out  remainder, registered, held until the next result
//   done  out  result valid (level), held in DONE
//   busy  out  division in progress (CALC or FIX)
//   dbz   out  divide-by-zero flag for the current result
// -----------------------------------------------------------------------------
module div_gen #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sgn,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             busy,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] y_q;      // dividend as latched, returned as r on divide-by-zero
  logic [WIDTH-1:0] dvd_q;    // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q;    // divisor magnitude
  logic [WIDTH:0]   rem_q;    // partial remainder
  logic [CW-1:0]    cnt_q;    // quotient bits still to produce, minus one
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             zero_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             done_q;
  logic             busy_q;
  logic             dbz_q;

  // Operand magnitudes for the accept edge.
  logic             y_neg;
  logic             x_neg;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH-1:0] x_mag;

  // One restoring-division step.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             fits;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] dvd_d;

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    y_neg = sgn & y[WIDTH-1];
    x_neg = sgn & x[WIDTH-1];
    // The most-negative value maps to 2**(WIDTH-1), which still fits unsigned.
    y_mag = y_neg ? ('0 - y) : y;
    x_mag = x_neg ? ('0 - x) : x;

    rem_sh = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    // Extra top bit acts as the borrow: set means the divisor does not fit.
    diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
    fits   = ~diff[WIDTH+1];
    rem_d  = fits ? diff[WIDTH:0] : rem_sh;
    dvd_d  = {dvd_q[WIDTH-2:0], fits};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset is synchronous; it wins over en and aborts any operation
      // without touching the datapath registers' meaning (they are reloaded
      // on the next accept anyway).
      state_q   <= IDLE;
      y_q       <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (en) begin
            y_q       <= y;
            dvd_q     <= y_mag;
            dvs_q     <= x_mag;
            rem_q     <= '0;
            cnt_q     <= CW'(WIDTH - 1);
            neg_quo_q <= y_neg ^ x_neg;
            neg_rem_q <= y_neg;
            zero_q    <= (x == '0);
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= (x == '0) ? FIX : CALC;
          end
        end

        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        FIX: begin
          if (zero_q) begin
            q_q <= '1;
            r_q <= y_q;
          end else begin
            q_q <= neg_quo_q ? ('0 - dvd_q) : dvd_q;
            r_q <= neg_rem_q ? ('0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
          end
          dbz_q   <= zero_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign done = done_q;
  assign busy = busy_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_div_gen.sv
// -----------------------------------------------------------------------------
// tb_div_gen -- self-checking bench for div_gen at WIDTH=32 and WIDTH=8.
// Expected results come from plain integer division on sign-extended values.
// -----------------------------------------------------------------------------
module tb_div_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en32, sgn32, done32, busy32, dbz32;
  logic [31:0] y32, x32, q32, r32;
  logic        en8, sgn8, done8, busy8, dbz8;
  logic [7:0]  y8, x8, q8, r8;

  div_gen #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .en(en32), .sgn(sgn32), .y(y32), .x(x32),
    .q(q32), .r(r32), .done(done32), .busy(busy32), .dbz(dbz32)
  );

  div_gen #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .sgn(sgn8), .y(y8), .x(x8),
    .q(q8), .r(r8), .done(done8), .busy(busy8), .dbz(dbz8)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          sel8     = 1'b0;
  int          edges    = 0;
  logic [63:0] exp_q, exp_r;
  logic        exp_dbz;
  int          exp_lat;

  function automatic logic [63:0] cur_q();
    return sel8 ? {56'd0, q8} : {32'd0, q32};
  endfunction
  function automatic logic [63:0] cur_r();
    return sel8 ? {56'd0, r8} : {32'd0, r32};
  endfunction
  function automatic logic cur_done();
    return sel8 ? done8 : done32;
  endfunction
  function automatic logic cur_busy();
    return sel8 ? busy8 : busy32;
  endfunction
  function automatic logic cur_dbz();
    return sel8 ? dbz8 : dbz32;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: truncating division on w-bit values, dbz convention for x==0.
  task automatic model(input int w, input bit s, input logic [63:0] yv, input logic [63:0] xv,
                       output logic [63:0] mq, output logic [63:0] mr, output logic md);
    logic [63:0] mask;
    longint      ys, xs;
    mask = (64'd1 << w) - 64'd1;
    if (xv == 64'd0) begin
      mq = mask;
      mr = yv;
      md = 1'b1;
    end else if (!s) begin
      mq = yv / xv;
      mr = yv % xv;
      md = 1'b0;
    end else begin
      ys = $signed(yv << (64 - w)) >>> (64 - w);
      xs = $signed(xv << (64 - w)) >>> (64 - w);
      mq = 64'(ys / xs) & mask;
      mr = 64'(ys % xs) & mask;
      md = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic set_en(input bit e);
    if (sel8) en8 = e; else en32 = e;
  endtask

  task automatic drive(input bit s, input logic [63:0] yv, input logic [63:0] xv);
    if (sel8) begin
      sgn8 = s; y8 = yv[7:0]; x8 = xv[7:0];
    end else begin
      sgn32 = s; y32 = yv[31:0]; x32 = xv[31:0];
    end
  endtask

  task automatic expect_op(input bit w8, input bit s, input logic [63:0] yv, input logic [63:0] xv);
    int          w;
    logic [63:0] mask;
    w    = w8 ? 8 : 32;
    mask = (64'd1 << w) - 64'd1;
    model(w, s, yv & mask, xv & mask, exp_q, exp_r, exp_dbz);
    exp_lat = exp_dbz ? 2 : w + 2;
  endtask

  task automatic start_op(input string tag, input bit w8, input bit s,
                          input logic [63:0] yv, input logic [63:0] xv, input bit keep);
    sel8 = w8;
    expect_op(w8, s, yv, xv);
    drive(s, yv, xv);
    set_en(1'b1);
    edges = 0;
    step();
    check({tag, "_acc_busy"}, 64'(cur_busy()), 64'd1);
    check({tag, "_acc_done"}, 64'(cur_done()), 64'd0);
    if (!keep) set_en(1'b0);
  endtask

  task automatic finish_op(input string tag);
    bit bad = 1'b0;
    while (!cur_done() && edges < 200) begin
      if (cur_busy() !== 1'b1) bad = 1'b1;
      step();
    end
    check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
    check({tag, "_busy_run"}, 64'(bad), 64'd0);
    check({tag, "_q"}, cur_q(), exp_q);
    check({tag, "_r"}, cur_r(), exp_r);
    check({tag, "_dbz"}, 64'(cur_dbz()), 64'(exp_dbz));
    check({tag, "_busy_end"}, 64'(cur_busy()), 64'd0);
  endtask

  task automatic run(input string tag, input bit w8, input bit s,
                     input logic [63:0] yv, input logic [63:0] xv);
    start_op(tag, w8, s, yv, xv, 1'b0);
    finish_op(tag);
  endtask

  initial begin
    bit          bad;
    logic [63:0] ry, rx;
    bit          rs;

    rst  = 1'b1;
    en32 = 1'b1; sgn32 = 1'b0; y32 = 32'd5; x32 = 32'd1;
    en8  = 1'b1; sgn8  = 1'b0; y8  = 8'd5;  x8  = 8'd1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q32", 64'(q32), 64'd0);
    check("rst_r32", 64'(r32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_dbz32", 64'(dbz32), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_q8", 64'(q8), 64'd0);
    en32 = 1'b0; en8 = 1'b0;
    rst  = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases.
    run("u65536", 1'b0, 1'b0, 64'd65536, 64'd16);
    check("u65536_lit_q", 64'(q32), 64'd4096);
    run("s_m7_2", 1'b0, 1'b1, 64'hFFFF_FFF9, 64'd2);
    check("s_m7_2_lit_q", 64'(q32), 64'hFFFF_FFFD);
    check("s_m7_2_lit_r", 64'(r32), 64'hFFFF_FFFF);
    run("s_7_m2", 1'b0, 1'b1, 64'd7, 64'hFFFF_FFFE);
    check("s_7_m2_lit_r", 64'(r32), 64'd1);
    run("dbz_u", 1'b0, 1'b0, 64'd123, 64'd0);
    check("dbz_u_lit_q", 64'(q32), 64'hFFFF_FFFF);
    run("dbz_s", 1'b0, 1'b1, 64'd123, 64'd0);
    check("dbz_s_lit_r", 64'(r32), 64'd123);
    run("ovf", 1'b0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF);
    check("ovf_lit_q", 64'(q32), 64'h8000_0000);
    run("u8_200_7", 1'b1, 1'b0, 64'd200, 64'd7);
    check("u8_lit_q", 64'(q8), 64'd28);
    check("u8_lit_r", 64'(r8), 64'd4);
    run("s8_80_3", 1'b1, 1'b1, 64'h80, 64'h03);
    check("s8_lit_q", 64'(q8), 64'hD6);
    check("s8_lit_r", 64'(r8), 64'hFE);

    // en re-pulsed mid-operation is ignored.
    start_op("ign", 1'b0, 1'b0, 64'd65536, 64'd16, 1'b0);
    repeat (3) step();
    en32 = 1'b1; y32 = 32'd1; x32 = 32'd1;
    step();
    en32 = 1'b0;
    finish_op("ign");

    // Reset mid-operation aborts with no result.
    start_op("abort", 1'b0, 1'b0, 64'd65536, 64'd16, 1'b0);
    repeat (8) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_q", 64'(q32), 64'd0);
    check("abort_r", 64'(r32), 64'd0);
    check("abort_done", 64'(done32), 64'd0);
    check("abort_busy", 64'(busy32), 64'd0);
    check("abort_dbz", 64'(dbz32), 64'd0);
    bad = 1'b0;
    repeat (40) begin
      step();
      if (done32 || busy32) bad = 1'b1;
    end
    check("abort_quiet", 64'(bad), 64'd0);
    run("post_rst", 1'b0, 1'b0, 64'd1000000, 64'd37);

    // Back-to-back: en held high through an operation and into DONE.
    start_op("b2b_a", 1'b0, 1'b0, 64'd100, 64'd7, 1'b1);
    y32 = 32'd1000; x32 = 32'd9;
    finish_op("b2b_a");
    expect_op(1'b0, 1'b0, 64'd1000, 64'd9);
    edges = 0;
    step();
    check("b2b_acc_done", 64'(done32), 64'd0);
    check("b2b_acc_busy", 64'(busy32), 64'd1);
    check("b2b_hold_q", 64'(q32), 64'd14);
    finish_op("b2b_b");
    en32 = 1'b0;
    step();
    check("b2b_done_held", 64'(done32), 64'd1);
    check("b2b_dbz_held", 64'(dbz32), 64'd0);

    // Randomized operations in both widths and modes.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ry = 64'($urandom);
      rx = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom);
      run("rnd8", 1'b1, rs, ry, rx);
    end
    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom_range(0, 1));
      ry = 64'($urandom);
      case ($urandom_range(0, 5))
        0:       rx = 64'd0;
        1:       rx = 64'($urandom_range(1, 15));
        2:       rx = 64'hFFFF_FFFF;
        default: rx = 64'($urandom);
      endcase
      run("rnd32", 1'b0, rs, ry, rx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
